elevator_car_ctrl: RTL
======================

# elevator_car_ctrl

Car motion controller for the elevator datapath. It accepts a floor request, latches it as `target_floor`, and drives `current_floor` and `target_floor` into the floor comparator. It consumes the comparator's `lt`/`gt`/`eq` verdict to step the car up or down one floor at a time, then opens the door for a fixed dwell. It owns the car position register that the comparator only reads.

## Interface
- `FLOOR_W`, 2: floor index width; floors are 0..2^FLOOR_W-1.
- `TRAVEL_CYCLES`, 8: cycles spent in motion per floor step (≥1).
- `DOOR_CYCLES`, 16: cycles the door stays open (≥1).

- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, 1: floor request present.
- `req_floor`, in, FLOOR_W: requested floor.
- `req_ready`, out, 1: request accepted this cycle if `req_valid`; high only in IDLE.
- `lt`, in, 1: comparator verdict, current above target (move down).
- `gt`, in, 1: comparator verdict, current below target (move up).
- `eq`, in, 1: comparator verdict, at target.
- `current_floor`, out, FLOOR_W: car position register, to comparator.
- `target_floor`, out, FLOOR_W: latched request, to comparator.
- `moving_up`, out, 1: high in state UP.
- `moving_down`, out, 1: high in state DOWN.
- `door_open`, out, 1: high in state DOOR.
- `arrived`, out, 1: one-cycle pulse on the first DOOR cycle.
- `busy`, out, 1: high in any state except IDLE.

## Operation
- States: IDLE, EVAL, UP, DOWN, DOOR.
- IDLE: `req_ready`=1. On `req_valid`, latch `target_floor`=`req_floor` and go to EVAL. Otherwise hold.
- EVAL: priority `eq` > `gt` > `lt`.
  - `eq` goes to DOOR.
  - `gt` goes to UP.
  - `lt` goes to DOWN.
  - No bit set (comparator in reset): remain in EVAL.
- UP/DOWN: travel counter loads `TRAVEL_CYCLES`-1 on entry and decrements each cycle. At the edge where it reads 0, `current_floor` is ±1 and the next state is EVAL.
- Position guard: UP at max floor or DOWN at floor 0 does not change `current_floor` and returns to EVAL. This covers an inconsistent verdict, so there is no wrap-around.
- DOOR: door counter loads `DOOR_CYCLES`-1 on entry. When it reaches 0, go to IDLE. `target_floor` holds its value.
- `req_valid` outside IDLE is ignored. The requester holds it until `req_ready`. Requests are not queued.
- Reset values: state IDLE; `current_floor`=0, `target_floor`=0; counters 0; `moving_up`=0, `moving_down`=0, `door_open`=0, `arrived`=0, `busy`=0; `req_ready`=1 from the first cycle after reset.
- Reset mid-motion or mid-door aborts immediately. The car position returns to 0 (models a homing reset).

## Timing
- All outputs are registered, or decoded from the registered state only. `req_ready` is state-decoded, with no combinational path from `req_valid`.
- `lt`/`gt`/`eq` are combinational from the outputs of this block and are sampled in EVAL the same cycle.
- Request accepted at edge N: EVAL at N+1. First motion state at N+2, or DOOR at N+2 if already at the floor.
- Per floor step: `TRAVEL_CYCLES` cycles in UP/DOWN plus 1 cycle in EVAL.
- Trip of k floors: accept-to-`arrived` = 1 + k·(TRAVEL_CYCLES+1) + 1 cycles. `door_open` lasts exactly `DOOR_CYCLES` cycles. `req_ready` rises on the cycle after the last DOOR cycle.
- `current_floor` changes only on the edge leaving UP/DOWN, so the comparator input is stable during EVAL.

## Structure
- `elevator_pkg`: state enum (IDLE, EVAL, UP, DOWN, DOOR), default `FLOOR_W`, `TRAVEL_CYCLES`, `DOOR_CYCLES` constants. Shared with the comparator and the future request scheduler.
- One sub-module, `elevator_timer`: loadable down-counter with `load`, `load_val`, and a `zero` flag. Instantiated once and shared by the travel and door phases, which are mutually exclusive.
- The comparator is instantiated at the top level, not inside this block.

## Test plan
- Reset, then request floor 2 from floor 0 (T=8, D=16):
  - `moving_up` for cycles 2–9 and 11–18.
  - `current_floor` becomes 1 at edge 10 and 2 at edge 19.
  - `arrived` at cycle 20; `door_open` cycles 20–35; `req_ready` at 36.
- At floor 3, request floor 0: three DOWN steps, `current_floor` 3→2→1→0, no underflow, `arrived` once.
- Request the current floor (1→1): EVAL then DOOR at N+2, with no `moving_*` activity.
- Assert `req_valid`=1 with `req_floor`=3 throughout a trip to floor 2: `req_ready`=0 until the door closes. The floor-3 request is then accepted and the car travels one floor up.
- Assert `rst` in cycle 5 of an UP phase: next cycle all outputs are at reset values and `current_floor`=0. A new request proceeds normally.
- Force `lt`=`gt`=`eq`=0 in EVAL for 4 cycles: state holds EVAL and `current_floor` is unchanged. It resumes once `eq` or `gt` returns.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: FSM state codes and default car parameters.
// Used by the car controller, the floor comparator and the request scheduler.
package elevator_pkg;

    localparam int unsigned FLOOR_W_DEF       = 2;
    localparam int unsigned TRAVEL_CYCLES_DEF = 8;
    localparam int unsigned DOOR_CYCLES_DEF   = 16;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EVAL = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DOOR = 3'd4;

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door phases.
// zero is registered and always mirrors (count == 0).
module elevator_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car motion controller: latches a floor request, steps the car one floor at a
// time using the external comparator verdict, then holds the door open.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned FLOOR_W       = FLOOR_W_DEF,
    parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int unsigned DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    input  logic               lt,
    input  logic               gt,
    input  logic               eq,
    output logic [FLOOR_W-1:0] current_floor,
    output logic [FLOOR_W-1:0] target_floor,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_open,
    output logic               arrived,
    output logic               busy
);

    localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = {FLOOR_W{1'b1}};

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] cur_q, cur_d;
    logic [FLOOR_W-1:0] tgt_q, tgt_d;
    logic               req_ready_q, moving_up_q, moving_down_q;
    logic               door_open_q, arrived_q, busy_q;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero;

    elevator_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next state; the floor register moves only on the edge leaving UP/DOWN.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tgt_d   = req_floor;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (eq) begin
                    state_d  = S_DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(DOOR_CYCLES - 1);
                end else if (gt) begin
                    state_d  = S_UP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(TRAVEL_CYCLES - 1);
                end else if (lt) begin
                    state_d  = S_DOWN;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(TRAVEL_CYCLES - 1);
                end
            end
            S_UP: begin
                if (tmr_zero) begin
                    state_d = S_EVAL;
                    if (cur_q != TOP_FLOOR) begin
                        cur_d = cur_q + FLOOR_W'(1);
                    end
                end
            end
            S_DOWN: begin
                if (tmr_zero) begin
                    state_d = S_EVAL;
                    if (cur_q != '0) begin
                        cur_d = cur_q - FLOOR_W'(1);
                    end
                end
            end
            S_DOOR: begin
                if (tmr_zero) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset homes the car to floor 0 and aborts any trip in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_q         <= '0;
            tgt_q         <= '0;
            req_ready_q   <= 1'b1;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
            arrived_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            tgt_q         <= tgt_d;
            req_ready_q   <= (state_d == S_IDLE);
            moving_up_q   <= (state_d == S_UP);
            moving_down_q <= (state_d == S_DOWN);
            door_open_q   <= (state_d == S_DOOR);
            arrived_q     <= (state_d == S_DOOR) && (state_q != S_DOOR);
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign req_ready     = req_ready_q;
    assign current_floor = cur_q;
    assign target_floor  = tgt_q;
    assign moving_up     = moving_up_q;
    assign moving_down   = moving_down_q;
    assign door_open     = door_open_q;
    assign arrived       = arrived_q;
    assign busy          = busy_q;

endmodule
